// File: rtl/ikaopll_pg_slotseq_pkg.sv
// Shared types and constants for the PG slot sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   NUM_SLOTS    operator slots per frame for the default 9-channel build
//   wr_sel_e     register-write target select codes
//   pg_slot_t    per-slot parameter bundle presented to the phase generator
//   slot_to_ch   slot index -> channel index helper
package ikaopll_pkg;

    localparam int NUM_SLOTS = 18;

    typedef enum logic [1:0] {
        WR_SEL_FNUML  = 2'd0,   // FNUM[7:0]
        WR_SEL_BLKKON = 2'd1,   // {KON, BLOCK[2:0], FNUM[8]}
        WR_SEL_MULPM  = 2'd2,   // {PM, MUL[3:0]}
        WR_SEL_RSVD   = 2'd3    // no target, write is dropped
    } wr_sel_e;

    typedef struct packed {
        logic [4:0] slot;
        logic       frame_start;
        logic [8:0] fnum;
        logic [2:0] block;
        logic [3:0] mul;
        logic       pm;
        logic       phase_rst;
    } pg_slot_t;

    // Value held by the output register while in reset: slot 0, frame start.
    localparam pg_slot_t PG_SLOT_RST = '{
        slot:        5'd0,
        frame_start: 1'b1,
        fnum:        9'd0,
        block:       3'd0,
        mul:         4'd0,
        pm:          1'b0,
        phase_rst:   1'b0
    };

    // Both operators of a channel sit in adjacent slots: even = modulator,
    // odd = carrier.
    function automatic logic [4:0] slot_to_ch(input logic [4:0] slot);
        return slot >> 1;
    endfunction

endpackage

// File: rtl/ikaopll_pg_slotseq_if.sv
// Register-write bus in, per-slot PG parameter bus out.
// Latency: n/a (wiring only).
// Backpressure: none; writes are single-cycle strobes, the PG side is a free-running stream.
//
// Signals:
//   wr_en/wr_sel/wr_idx/wr_data  register write strobe and payload (master -> sequencer)
//   pg                           parameters of the currently presented slot
//   pmval                        shared vibrato step
// Modports: master = register side / PG consumer, slave = sequencer.
interface ikaopll_pg_slotseq_if;
    import ikaopll_pkg::*;

    logic       wr_en;
    logic [1:0] wr_sel;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;
    pg_slot_t   pg;
    logic [2:0] pmval;

    modport master (
        output wr_en, wr_sel, wr_idx, wr_data,
        input  pg, pmval
    );

    modport slave (
        input  wr_en, wr_sel, wr_idx, wr_data,
        output pg, pmval
    );

endinterface

// File: rtl/ikaopll_pg_slotseq_pmlfo.sv
// Frame divider and 3-bit vibrato step counter (PMVAL).
// Latency: PMVAL steps on the enabled edge carrying the PMVAL_DIV-th frame wrap.
// Backpressure: none; frozen while the enable is low.
//
// Ports:
//   emuclk  clock
//   rst     synchronous active-high reset
//   en      slot-advance enable (active high here)
//   wrap    high on the slot that wraps 17 -> 0
//   pmval   shared vibrato step, mod 8
module ikaopll_pg_pmlfo #(
    parameter int PMVAL_DIV = 1024
) (
    input  logic       emuclk,
    input  logic       rst,
    input  logic       en,
    input  logic       wrap,
    output logic [2:0] pmval
);

    localparam int FW = (PMVAL_DIV > 2) ? $clog2(PMVAL_DIV) : 1;

    logic [FW-1:0] frame_cnt;

    // PMVAL_DIV is a power of two, so the divider terminal count is all-ones.
    always_ff @(posedge emuclk) begin
        if (rst) begin
            frame_cnt <= '0;
            pmval     <= 3'd0;
        end else if (en && wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (&frame_cnt) begin
                pmval <= pmval + 3'd1;
            end
        end
    end

endmodule

// File: rtl/ikaopll_pg_slotseq.sv
// Slot sequencer / parameter scheduler feeding the phase generator.
// Latency: outputs load the slot the counter moves to on the same enabled edge (0 enables).
// Backpressure: none; everything except register writes freezes while i_phi1_NCEN_n is high.
//
// Ports:
//   i_EMUCLK       only clock
//   i_RST          synchronous active-high reset, dominates enable and writes
//   i_phi1_NCEN_n  active-low slot-advance enable
//   bus            register writes in; slot, frame start, FNUM/BLOCK/MUL/PM,
//                  PMVAL and phase-reset strobe out
module ikaopll_pg_slotseq
    import ikaopll_pkg::*;
#(
    parameter int NUM_CH    = 9,
    parameter int PMVAL_DIV = 1024
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_RST,
    input  logic                  i_phi1_NCEN_n,
    ikaopll_pg_slotseq_if.slave   bus
);

    localparam int SLOTS = 2 * NUM_CH;
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OPW   = $clog2(SLOTS);

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [4:0] CH_LIM    = 5'(NUM_CH);
    localparam logic [4:0] OP_LIM    = 5'(SLOTS);

    // ------------------------------------------------------------------
    // Parameter registers (written from the register side)
    // ------------------------------------------------------------------
    logic [8:0]        fnum_r  [NUM_CH];
    logic [2:0]        block_r [NUM_CH];
    logic [NUM_CH-1:0] kon_r;
    logic [3:0]        mul_r   [SLOTS];
    logic [SLOTS-1:0]  pm_r;

    logic              wr_ch_ok;
    logic              wr_op_ok;
    logic [CHW-1:0]    wr_ch;
    logic [OPW-1:0]    wr_op;

    assign wr_ch_ok = (bus.wr_idx < CH_LIM);
    assign wr_op_ok = (bus.wr_idx < OP_LIM);
    assign wr_ch    = CHW'(bus.wr_idx);
    assign wr_op    = OPW'(bus.wr_idx);

    // Writes are not gated by the slot enable. A write landing on the same
    // edge that presents its own slot is invisible until the next frame,
    // because the presentation path below samples these registers pre-edge.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                fnum_r[c]  <= '0;
                block_r[c] <= '0;
            end
            for (int o = 0; o < SLOTS; o++) begin
                mul_r[o] <= '0;
            end
            kon_r <= '0;
            pm_r  <= '0;
        end else if (bus.wr_en) begin
            case (wr_sel_e'(bus.wr_sel))
                WR_SEL_FNUML: begin
                    if (wr_ch_ok) begin
                        fnum_r[wr_ch][7:0] <= bus.wr_data;
                    end
                end
                WR_SEL_BLKKON: begin
                    if (wr_ch_ok) begin
                        kon_r[wr_ch]       <= bus.wr_data[4];
                        block_r[wr_ch]     <= bus.wr_data[3:1];
                        fnum_r[wr_ch][8]   <= bus.wr_data[0];
                    end
                end
                WR_SEL_MULPM: begin
                    if (wr_op_ok) begin
                        pm_r[wr_op]  <= bus.wr_data[4];
                        mul_r[wr_op] <= bus.wr_data[3:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot walk and presentation
    // ------------------------------------------------------------------
    logic              en;
    logic              wrap;
    pg_slot_t          pg_q;
    pg_slot_t          pg_nxt;
    logic [4:0]        slot_nxt;
    logic [CHW-1:0]    ch_nxt;
    logic [OPW-1:0]    op_nxt;
    logic              prst_nxt;
    logic [NUM_CH-1:0] kon_seen;
    logic [NUM_CH-1:0] pend;

    assign en   = ~i_phi1_NCEN_n;
    // The presented slot register doubles as the slot counter.
    assign wrap = (pg_q.slot == SLOT_LAST);

    always_comb begin
        slot_nxt = wrap ? 5'd0 : pg_q.slot + 5'd1;
        ch_nxt   = CHW'(slot_to_ch(slot_nxt));
        op_nxt   = OPW'(slot_nxt);

        // Modulator slot detects the KON rising edge; carrier slot replays
        // the decision so both operators reset in the same frame.
        if (slot_nxt[0]) begin
            prst_nxt = pend[ch_nxt];
        end else begin
            prst_nxt = kon_r[ch_nxt] & ~kon_seen[ch_nxt];
        end

        pg_nxt             = PG_SLOT_RST;
        pg_nxt.slot        = slot_nxt;
        pg_nxt.frame_start = (slot_nxt == 5'd0);
        pg_nxt.fnum        = fnum_r[ch_nxt];
        pg_nxt.block       = block_r[ch_nxt];
        pg_nxt.mul         = mul_r[op_nxt];
        pg_nxt.pm          = pm_r[op_nxt];
        pg_nxt.phase_rst   = prst_nxt;
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            pg_q     <= PG_SLOT_RST;
            kon_seen <= '0;
            pend     <= '0;
        end else if (en) begin
            pg_q <= pg_nxt;
            if (slot_nxt[0]) begin
                // KON is only re-sampled once per frame, so a 1->0->1 glitch
                // between two carrier visits never registers as an edge.
                kon_seen[ch_nxt] <= kon_r[ch_nxt];
                pend[ch_nxt]     <= 1'b0;
            end else begin
                pend[ch_nxt]     <= prst_nxt;
            end
        end
    end

    assign bus.pg = pg_q;

    // ------------------------------------------------------------------
    // Shared vibrato step
    // ------------------------------------------------------------------
    ikaopll_pg_pmlfo #(
        .PMVAL_DIV (PMVAL_DIV)
    ) u_pmlfo (
        .emuclk (i_EMUCLK),
        .rst    (i_RST),
        .en     (en),
        .wrap   (wrap),
        .pmval  (bus.pmval)
    );

endmodule

// File: tb/tb_ikaopll_pg_slotseq.sv
// Self-checking bench for ikaopll_pg_slotseq: directed scenarios plus
// randomized traffic, every output compared each cycle against a
// frame-level reference model of the slot/channel rules.
module tb_ikaopll_pg_slotseq;
    import ikaopll_pkg::*;

    localparam int NUM_CH    = 9;
    localparam int SLOTS     = 18;
    localparam int PMVAL_DIV = 1024;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic ncen_n = 1'b1;

    always #5 clk = ~clk;

    ikaopll_pg_slotseq_if bus();

    ikaopll_pg_slotseq #(
        .NUM_CH    (NUM_CH),
        .PMVAL_DIV (PMVAL_DIV)
    ) dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen_n),
        .bus           (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_fnum [NUM_CH];
    int m_blk  [NUM_CH];
    int m_kon  [NUM_CH];
    int m_seen [NUM_CH];
    int m_pend [NUM_CH];
    int m_mul  [SLOTS];
    int m_pm   [SLOTS];
    int m_wraps;
    int e_slot, e_fs, e_fnum, e_blk, e_mul, e_pm, e_prst;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_fnum[c] = 0; m_blk[c] = 0; m_kon[c] = 0; m_seen[c] = 0; m_pend[c] = 0;
        end
        for (int o = 0; o < SLOTS; o++) begin
            m_mul[o] = 0; m_pm[o] = 0;
        end
        m_wraps = 0;
        e_slot = 0; e_fs = 1; e_fnum = 0; e_blk = 0; e_mul = 0; e_pm = 0; e_prst = 0;
    endtask

    // Evaluated just before a clock edge, using the inputs that edge will see.
    task automatic model_edge();
        int sel, idx, data, s, c;
        if (rst) begin
            model_reset();
            return;
        end
        if (!ncen_n) begin
            s = (e_slot + 1) % SLOTS;
            if (s == 0) m_wraps++;
            c = s / 2;
            e_slot = s;
            e_fs   = (s == 0);
            e_fnum = m_fnum[c];
            e_blk  = m_blk[c];
            e_mul  = m_mul[s];
            e_pm   = m_pm[s];
            if (s % 2 == 0) begin
                e_prst    = (m_kon[c] != 0 && m_seen[c] == 0);
                m_pend[c] = e_prst;
            end else begin
                e_prst    = m_pend[c];
                m_seen[c] = m_kon[c];
                m_pend[c] = 0;
            end
        end
        if (bus.wr_en) begin
            sel  = int'(bus.wr_sel);
            idx  = int'(bus.wr_idx);
            data = int'(bus.wr_data);
            if (sel == 0 && idx < NUM_CH) begin
                m_fnum[idx] = (m_fnum[idx] & 'h100) | data;
            end else if (sel == 1 && idx < NUM_CH) begin
                m_kon[idx]  = (data >> 4) & 1;
                m_blk[idx]  = (data >> 1) & 7;
                m_fnum[idx] = (m_fnum[idx] & 'hFF) | ((data & 1) << 8);
            end else if (sel == 2 && idx < SLOTS) begin
                m_pm[idx]  = (data >> 4) & 1;
                m_mul[idx] = data & 15;
            end
        end
    endtask

    task automatic compare_all();
        check("slot",        bus.pg.slot,        e_slot);
        check("frame_start", bus.pg.frame_start, e_fs);
        check("fnum",        bus.pg.fnum,        e_fnum);
        check("block",       bus.pg.block,       e_blk);
        check("mul",         bus.pg.mul,         e_mul);
        check("pm",          bus.pg.pm,          e_pm);
        check("phase_rst",   bus.pg.phase_rst,   e_prst);
        check("pmval",       bus.pmval,          (m_wraps / PMVAL_DIV) % 8);
    endtask

    // One EMUCLK cycle with the given enable / write / reset inputs.
    task automatic cyc(input bit en, input bit we, input int sel, input int idx,
                       input int data, input bit r);
        ncen_n      = !en;
        bus.wr_en   = we;
        bus.wr_sel  = 2'(sel);
        bus.wr_idx  = 5'(idx);
        bus.wr_data = 8'(data);
        rst         = r;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        bus.wr_en = 1'b0;
        rst       = 1'b0;
        ncen_n    = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic advance_to(input int s);
        for (int i = 0; i < SLOTS; i++) begin
            if (e_slot == s) break;
            cyc(1, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            if (bus.pg.phase_rst) cnt++;
        end
    endtask

    int np;
    int bad;
    int wraps;

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_idx = '0; bus.wr_data = '0;
        model_reset();

        // Reset state
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("rst_slot",  bus.pg.slot,        0);
        check("rst_fs",    bus.pg.frame_start, 1);
        check("rst_fnum",  bus.pg.fnum,        0);
        check("rst_pmval", bus.pmval,          0);
        check("rst_prst",  bus.pg.phase_rst,   0);

        // Two full frames of slot walking
        for (int i = 0; i < 36; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("seq_slot", bus.pg.slot, (i + 1) % SLOTS);
            check("seq_fs",   bus.pg.frame_start, ((i + 1) % SLOTS) == 0);
        end

        // Channel 4 FNUM=0x1A5, BLOCK=5
        cyc(0, 1, 0, 4, 'hA5, 0);
        cyc(0, 1, 1, 4, 'h0B, 0);
        for (int i = 0; i < SLOTS; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("ch4_fnum",  bus.pg.fnum,
                  (bus.pg.slot == 8 || bus.pg.slot == 9) ? 32'h1A5 : 32'h0);
            check("ch4_block", bus.pg.block,
                  (bus.pg.slot == 8 || bus.pg.slot == 9) ? 32'd5 : 32'd0);
        end

        // Operator 7 write coincident with its presentation
        advance_to(6);
        cyc(1, 1, 2, 7, 'h1C, 0);
        check("op7_same_slot", bus.pg.slot, 7);
        check("op7_same_mul",  bus.pg.mul,  0);
        check("op7_same_pm",   bus.pg.pm,   0);
        run(SLOTS);
        check("op7_next_slot", bus.pg.slot, 7);
        check("op7_next_mul",  bus.pg.mul,  12);
        check("op7_next_pm",   bus.pg.pm,   1);

        // KON on channel 2 set mid-frame
        advance_to(10);
        cyc(0, 1, 1, 2, 'h10, 0);
        np = 0; bad = 0;
        for (int i = 0; i < 3 * SLOTS; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            if (bus.pg.phase_rst) begin
                np++;
                if (!(i < SLOTS && (bus.pg.slot == 4 || bus.pg.slot == 5))) bad++;
            end
        end
        check("kon_pulses", np, 2);
        check("kon_where",  bad, 0);
        // Clear across a frame, then set again
        cyc(0, 1, 1, 2, 'h00, 0);
        run(SLOTS);
        cyc(0, 1, 1, 2, 'h10, 0);
        count_pulses(2 * SLOTS, np);
        check("kon_repulse", np, 2);
        // 1->0->1 between two visits: no edge seen
        advance_to(6);
        cyc(0, 1, 1, 2, 'h00, 0);
        cyc(0, 1, 1, 2, 'h10, 0);
        count_pulses(2 * SLOTS, np);
        check("kon_glitch", np, 0);

        // Reset at slot 11 with channel 5 pending
        advance_to(11);
        cyc(0, 1, 1, 5, 'h10, 0);
        advance_to(10);
        check("ch5_even_prst", bus.pg.phase_rst, 1);
        cyc(1, 0, 0, 0, 0, 1);
        check("midrst_slot",  bus.pg.slot,      0);
        check("midrst_pmval", bus.pmval,        0);
        check("midrst_prst",  bus.pg.phase_rst, 0);
        count_pulses(2 * SLOTS, np);
        check("midrst_pulses", np, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 3),
                $urandom_range(0, 31),
                $urandom_range(0, 255),
                $urandom_range(0, 499) == 0);
        end

        // Vibrato step over three divider periods
        cyc(0, 0, 0, 0, 0, 1);
        wraps = 0;
        for (int i = 0; i < SLOTS * PMVAL_DIV * 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            if (bus.pg.slot == 0) begin
                wraps++;
                if (wraps == 1023) check("pmval_w1023", bus.pmval, 0);
                if (wraps == 1024) check("pmval_w1024", bus.pmval, 1);
                if (wraps == 2047) check("pmval_w2047", bus.pmval, 1);
                if (wraps == 2048) check("pmval_w2048", bus.pmval, 2);
                if (wraps == 3071) check("pmval_w3071", bus.pmval, 2);
                if (wraps == 3072) check("pmval_w3072", bus.pmval, 3);
            end
        end
        check("pmval_wraps", wraps, 3072);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
